// File: rtl/ras_pkg.sv
// Shared types and index helpers for the speculative return-address stack.
// RasCkpt here has the default geometry (8 entries, 31-bit addresses); the stack builds its own parameterised copy.
package ras_pkg;

  localparam int unsigned RAS_DEF_ENTRIES = 8;
  localparam int unsigned RAS_DEF_ADDR_W  = 31;
  localparam int unsigned RAS_DEF_IDX_W   = $clog2(RAS_DEF_ENTRIES);
  localparam int unsigned RAS_DEF_CNT_W   = RAS_DEF_IDX_W + 1;

  // Field order gives {idx, cnt, top} with idx in the most significant bits.
  typedef struct packed {
    logic [RAS_DEF_IDX_W-1:0]  idx;
    logic [RAS_DEF_CNT_W-1:0]  cnt;
    logic [RAS_DEF_ADDR_W-1:0] top;
  } RasCkpt;

  typedef enum logic [1:0] {
    RAS_RESTORE_NONE = 2'd0,
    RAS_RESTORE_PUSH = 2'd1,
    RAS_RESTORE_POP  = 2'd2
  } RasRestoreOp;

  // Stack depth is a power of two, so wrapping is a mask.
  function automatic int unsigned ras_wrap(input int unsigned value, input int unsigned entries);
    return value & (entries - 1);
  endfunction

  function automatic int unsigned ras_inc(input int unsigned value, input int unsigned entries);
    return ras_wrap(value + 1, entries);
  endfunction

  function automatic int unsigned ras_dec(input int unsigned value, input int unsigned entries);
    return ras_wrap(value + entries - 1, entries);
  endfunction

endpackage

// File: rtl/return_stack_ckpt.sv
// Circular speculative return-address stack with one-cycle checkpoint restore.
// A restore can also apply the corrected push or pop in the same cycle.
module return_stack_ckpt
  import ras_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ADDR_W      = 31,
  localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES),
  localparam int unsigned CNT_W      = IDX_W + 1,
  localparam int unsigned CKPT_W     = IDX_W + CNT_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_push,
  input  logic [ADDR_W-1:0] IN_pushData,
  input  logic              IN_pop,
  output logic              OUT_valid,
  output logic [ADDR_W-1:0] OUT_data,
  output logic [CKPT_W-1:0] OUT_ckpt,
  output logic              OUT_overflow,
  input  logic              IN_restore,
  input  logic [CKPT_W-1:0] IN_restoreCkpt,
  input  logic [1:0]        IN_restoreOp,
  input  logic [ADDR_W-1:0] IN_restoreData
);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] top;
  } ckpt_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

  logic [ADDR_W-1:0] mem [NUM_ENTRIES];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overflow_d;

  logic              we0, we1;
  logic [IDX_W-1:0]  wa0, wa1;
  logic [ADDR_W-1:0] wd0, wd1;

  ckpt_t             rst_ckpt;
  RasRestoreOp       restore_op;
  logic [IDX_W-1:0]  idx_inc, idx_dec, ridx_inc, ridx_dec;

  assign rst_ckpt   = ckpt_t'(IN_restoreCkpt);
  assign restore_op = RasRestoreOp'(IN_restoreOp);

  assign idx_inc  = IDX_W'(ras_inc(32'(idx_q), NUM_ENTRIES));
  assign idx_dec  = IDX_W'(ras_dec(32'(idx_q), NUM_ENTRIES));
  assign ridx_inc = IDX_W'(ras_inc(32'(rst_ckpt.idx), NUM_ENTRIES));
  assign ridx_dec = IDX_W'(ras_dec(32'(rst_ckpt.idx), NUM_ENTRIES));

  // Port 0 carries the normal write or the top repair; port 1 only the restore push.
  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    overflow_d = 1'b0;
    we0        = 1'b0;
    wa0        = idx_q;
    wd0        = IN_pushData;
    we1        = 1'b0;
    wa1        = rst_ckpt.idx;
    wd1        = IN_restoreData;

    if (IN_restore) begin
      idx_d = rst_ckpt.idx;
      cnt_d = rst_ckpt.cnt;
      if (rst_ckpt.cnt != '0) begin
        we0 = 1'b1;
        wa0 = ridx_dec;
        wd0 = rst_ckpt.top;
      end
      case (restore_op)
        RAS_RESTORE_PUSH: begin
          we1   = 1'b1;
          idx_d = ridx_inc;
          if (rst_ckpt.cnt == FULL_CNT) begin
            overflow_d = 1'b1;
          end else begin
            cnt_d = rst_ckpt.cnt + 1'b1;
          end
        end
        RAS_RESTORE_POP: begin
          if (rst_ckpt.cnt != '0) begin
            idx_d = ridx_dec;
            cnt_d = rst_ckpt.cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end else if (IN_push && IN_pop && cnt_q != '0) begin
      we0 = 1'b1;
      wa0 = idx_dec;
    end else if (IN_push) begin
      we0   = 1'b1;
      idx_d = idx_inc;
      if (cnt_q == FULL_CNT) begin
        overflow_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (IN_pop && cnt_q != '0) begin
      idx_d = idx_dec;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      OUT_overflow <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      OUT_overflow <= overflow_d;
    end
  end

  // Storage is not reset; the two write slots always differ.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign OUT_valid = (cnt_q != '0);
  assign OUT_data  = mem[idx_dec];
  assign OUT_ckpt  = {idx_q, cnt_q, OUT_data};

endmodule

// File: tb/tb_return_stack_ckpt.sv
// Directed bench for return_stack_ckpt at depth 4, with hand-computed expectations.
module tb_return_stack_ckpt;

  localparam int unsigned N      = 4;
  localparam int unsigned AW     = 31;
  localparam int unsigned CKPT_W = 2 + 3 + AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              IN_push = 1'b0;
  logic [AW-1:0]     IN_pushData = '0;
  logic              IN_pop = 1'b0;
  logic              OUT_valid;
  logic [AW-1:0]     OUT_data;
  logic [CKPT_W-1:0] OUT_ckpt;
  logic              OUT_overflow;
  logic              IN_restore = 1'b0;
  logic [CKPT_W-1:0] IN_restoreCkpt = '0;
  logic [1:0]        IN_restoreOp = '0;
  logic [AW-1:0]     IN_restoreData = '0;

  int total = 0;
  int bad   = 0;
  logic [CKPT_W-1:0] saved;

  return_stack_ckpt #(.NUM_ENTRIES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .IN_push(IN_push), .IN_pushData(IN_pushData), .IN_pop(IN_pop),
    .OUT_valid(OUT_valid), .OUT_data(OUT_data), .OUT_ckpt(OUT_ckpt),
    .OUT_overflow(OUT_overflow),
    .IN_restore(IN_restore), .IN_restoreCkpt(IN_restoreCkpt),
    .IN_restoreOp(IN_restoreOp), .IN_restoreData(IN_restoreData)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge with inputs idle.
  task automatic applyStimulus(input logic push, input logic pop, input logic [AW-1:0] data,
                               input logic restore, input logic [CKPT_W-1:0] ckpt,
                               input logic [1:0] op, input logic [AW-1:0] rdata);
    IN_push = push; IN_pop = pop; IN_pushData = data;
    IN_restore = restore; IN_restoreCkpt = ckpt; IN_restoreOp = op; IN_restoreData = rdata;
    @(posedge clk);
    #1;
    IN_push = 1'b0; IN_pop = 1'b0; IN_restore = 1'b0;
  endtask

  task automatic doPush(input logic [AW-1:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, '0, 2'd0, '0);
  endtask

  task automatic doPop();
    applyStimulus(1'b0, 1'b1, '0, 1'b0, '0, 2'd0, '0);
  endtask

  task automatic doRestore(input logic [CKPT_W-1:0] c, input logic [1:0] op, input logic [AW-1:0] d);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, c, op, d);
  endtask

  function automatic logic [4:0] idxCnt();
    return OUT_ckpt[CKPT_W-1:AW];
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(OUT_valid), 64'd0);
    checkOutput("reset_ovf", 64'(OUT_overflow), 64'd0);
    checkOutput("reset_idxcnt", 64'(idxCnt()), 64'd0);
    rst = 1'b1;

    doPush(31'h100);
    doPush(31'h200);
    checkOutput("push2_data", 64'(OUT_data), 64'h200);
    checkOutput("push2_valid", 64'(OUT_valid), 64'd1);
    checkOutput("push2_idxcnt", 64'(idxCnt()), 64'({2'd2, 3'd2}));
    doPop();
    checkOutput("pop_data", 64'(OUT_data), 64'h100);
    doPop();
    checkOutput("pop_empty_valid", 64'(OUT_valid), 64'd0);

    for (int i = 1; i <= 4; i++) begin
      doPush(AW'(i));
      checkOutput("fill_ovf", 64'(OUT_overflow), 64'd0);
    end
    doPush(31'h5);
    checkOutput("ovf_pulse", 64'(OUT_overflow), 64'd1);
    checkOutput("ovf_data", 64'(OUT_data), 64'h5);
    checkOutput("ovf_idxcnt", 64'(idxCnt()), 64'({2'd1, 3'd4}));
    doPop();
    checkOutput("ovf_pulse_end", 64'(OUT_overflow), 64'd0);
    checkOutput("pop1_data", 64'(OUT_data), 64'h4);
    doPop();
    checkOutput("pop2_data", 64'(OUT_data), 64'h3);
    doPop();
    checkOutput("pop3_data", 64'(OUT_data), 64'h2);
    checkOutput("pop3_valid", 64'(OUT_valid), 64'd1);
    doPop();
    checkOutput("pop4_valid", 64'(OUT_valid), 64'd0);
    doPop();
    checkOutput("pop5_idxcnt", 64'(idxCnt()), 64'({2'd1, 3'd0}));

    applyStimulus(1'b1, 1'b1, 31'hA, 1'b0, '0, 2'd0, '0);
    checkOutput("pushpop_empty_data", 64'(OUT_data), 64'hA);
    checkOutput("pushpop_empty_idxcnt", 64'(idxCnt()), 64'({2'd2, 3'd1}));
    applyStimulus(1'b1, 1'b1, 31'hB, 1'b0, '0, 2'd0, '0);
    checkOutput("pushpop_data", 64'(OUT_data), 64'hB);
    checkOutput("pushpop_idxcnt", 64'(idxCnt()), 64'({2'd2, 3'd1}));

    doPush(31'h10);
    doPush(31'h20);
    saved = OUT_ckpt;
    checkOutput("ckpt_value", 64'(saved), 64'({2'd0, 3'd3, 31'h20}));
    doPop();
    doPush(31'h99);
    checkOutput("corrupt_data", 64'(OUT_data), 64'h99);
    doRestore(saved, 2'd0, '0);
    checkOutput("repair_data", 64'(OUT_data), 64'h20);
    checkOutput("repair_ckpt", 64'(OUT_ckpt), 64'({2'd0, 3'd3, 31'h20}));
    doPop();
    checkOutput("repair_pop1", 64'(OUT_data), 64'h10);
    doPop();
    checkOutput("repair_pop2", 64'(OUT_data), 64'hB);

    doRestore(saved, 2'd1, 31'h30);
    checkOutput("rpush_data", 64'(OUT_data), 64'h30);
    checkOutput("rpush_idxcnt", 64'(idxCnt()), 64'({2'd1, 3'd4}));
    checkOutput("rpush_ovf", 64'(OUT_overflow), 64'd0);
    doPop();
    checkOutput("rpush_pop", 64'(OUT_data), 64'h20);
    doRestore(saved, 2'd2, '0);
    checkOutput("rpop_data", 64'(OUT_data), 64'h10);
    checkOutput("rpop_idxcnt", 64'(idxCnt()), 64'({2'd3, 3'd2}));

    doRestore({2'd0, 3'd4, 31'h20}, 2'd1, 31'h44);
    checkOutput("rpush_full_ovf", 64'(OUT_overflow), 64'd1);
    checkOutput("rpush_full_ckpt", 64'(OUT_ckpt), 64'({2'd1, 3'd4, 31'h44}));

    applyStimulus(1'b1, 1'b1, 31'h77, 1'b1, {2'd2, 3'd2, 31'h10}, 2'd3, 31'h66);
    checkOutput("rpri_ckpt", 64'(OUT_ckpt), 64'({2'd2, 3'd2, 31'h10}));
    checkOutput("rpri_ovf", 64'(OUT_overflow), 64'd0);

    doRestore({2'd3, 3'd0, 31'h5}, 2'd2, '0);
    checkOutput("rpop_empty_valid", 64'(OUT_valid), 64'd0);
    checkOutput("rpop_empty_idxcnt", 64'(idxCnt()), 64'({2'd3, 3'd0}));

    doPush(31'h55);
    checkOutput("post_push_data", 64'(OUT_data), 64'h55);
    checkOutput("post_push_valid", 64'(OUT_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(OUT_valid), 64'd0);
    checkOutput("async_rst_idxcnt", 64'(idxCnt()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_stack_ckpt.md
Name: return_stack_ckpt

Overview:
Speculative return-address stack (RAS) for the branch predictor, with checkpoint and restore. The frontend pushes on predicted calls and pops on predicted returns. Each prediction carries a checkpoint. On a misprediction, the backend restores the stack to that checkpoint and can optionally apply the correct push or pop in the same cycle. The stack is circular: on overflow the oldest entry is overwritten.

Parameters:
- NUM_ENTRIES, 8: stack depth; must be a power of two, at least 2.
- ADDR_W, 31: width of a return address (halfword-aligned PC without bit 0).
- Derived: IDX_W = $clog2(NUM_ENTRIES).
- Derived: CNT_W = IDX_W+1.
- Derived: CKPT_W = IDX_W+CNT_W+ADDR_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- IN_push  in  1  predicted call; push IN_pushData.
- IN_pushData  in  ADDR_W  return address to push.
- IN_pop  in  1  predicted return; pop the top entry.
- OUT_valid  out  1  stack is non-empty (numFilled != 0).
- OUT_data  out  ADDR_W  top-of-stack entry, combinational.
- OUT_ckpt  out  CKPT_W  current state snapshot {index, numFilled, top entry}, combinational.
- OUT_overflow  out  1  registered one-cycle pulse: a push overwrote the oldest entry.
- IN_restore  in  1  misprediction recovery strobe.
- IN_restoreCkpt  in  CKPT_W  checkpoint to restore.
- IN_restoreOp  in  2  0 = restore only, 1 = restore then push, 2 = restore then pop, 3 = reserved (treated as 0).
- IN_restoreData  in  ADDR_W  address pushed when IN_restoreOp = 1.

Behaviour:
- State:
  - index (IDX_W bits): the next write slot.
  - numFilled (CNT_W bits): saturates at NUM_ENTRIES.
  - stack array.
- Reset (rst low, asynchronous):
  - index = 0, numFilled = 0, OUT_overflow = 0.
  - Array contents are not reset.
  - Outputs after reset: OUT_valid = 0; OUT_data is don't-care.
- OUT_data = stack[index-1], computed modulo NUM_ENTRIES; index 0 reads the entry at NUM_ENTRIES-1.
- OUT_ckpt packs {index, numFilled, OUT_data}, with index in the most significant bits.
- Priority: when IN_restore = 1, IN_push and IN_pop are ignored that cycle.
- Normal operation (IN_restore = 0):
  - Push only:
    - stack[index] <= data; index += 1, wrapping.
    - numFilled += 1, saturating at NUM_ENTRIES.
    - OUT_overflow <= 1 if numFilled was already NUM_ENTRIES.
  - Pop only with numFilled != 0: index -= 1, wrapping; numFilled -= 1.
  - Pop only with numFilled == 0: no state change.
  - Push and pop together with numFilled != 0:
    - stack[index-1] <= data (top replaced).
    - index and numFilled unchanged; no overflow pulse.
  - Push and pop together with numFilled == 0: treated as push only.
- Restore (IN_restore = 1), in one cycle:
  - index <= ckpt.index; numFilled <= ckpt.numFilled.
  - If ckpt.numFilled != 0, stack[ckpt.index-1] <= ckpt.top. This repairs a top entry corrupted by a wrong-path push.
  - Op 1: additionally write stack[ckpt.index] <= IN_restoreData.
    - Final index = ckpt.index+1; final numFilled = saturating ckpt.numFilled+1.
    - OUT_overflow follows the push-only rule.
  - Op 2 with ckpt.numFilled != 0:
    - Final index = ckpt.index-1; final numFilled = ckpt.numFilled-1.
    - The top repair write is still performed.
  - Op 2 with ckpt.numFilled == 0: same as op 0.
- Write ports: at most two array writes per cycle (op 1 with top repair), always to distinct slots.
- Latency:
  - A push is visible on OUT_data in the next cycle.
  - A restore is visible on OUT_valid, OUT_data and OUT_ckpt in the next cycle.
- OUT_overflow is high for exactly one cycle per overflowing push; otherwise 0.
- Reset asserted mid-operation wins immediately; no write is guaranteed in that cycle.

Decomposition:
- Package ras_pkg:
  - RasCkpt struct {idx, cnt, top}; packed bit order must match OUT_ckpt.
  - RasRestoreOp enum: RAS_RESTORE_NONE, RAS_RESTORE_PUSH, RAS_RESTORE_POP.
  - Helper function for modulo index arithmetic.
- No sub-module: storage, index logic and the restore mux stay in one module (around 150–250 lines).

Test Plan:
- Reset with NUM_ENTRIES = 4 -> OUT_valid = 0, OUT_overflow = 0.
  - Push 0x100, 0x200 -> OUT_data = 0x200, OUT_valid = 1.
  - Pop -> OUT_data = 0x100.
- Overflow: push 0x1..0x5 on a depth-4 stack -> OUT_overflow pulses once, on the 5th push.
  - Then 4 pops return 0x5, 0x4, 0x3, 0x2.
  - OUT_valid = 0 after the 4th pop; a 5th pop changes nothing.
- Empty stack, push and pop together with 0xA -> behaves as push: OUT_data = 0xA, numFilled = 1.
  - Next push+pop with 0xB -> OUT_data = 0xB, numFilled still 1.
- Corruption repair:
  - Push 0x10, 0x20, capture OUT_ckpt.
  - Pop, then push 0x99 (overwrites the 0x20 slot).
  - Restore op 0 -> OUT_data = 0x20; two pops yield 0x20, then 0x10.
- Restore with push: from the checkpoint of the previous scenario, restore op 1 with data 0x30 -> OUT_data = 0x30, next pop -> 0x20.
  - Restore op 2 -> OUT_data = 0x10.
- Restore asserted together with IN_push = 1 and IN_pop = 1 -> push and pop are ignored; the state equals the restore result.
  - Assert rst asynchronously mid-sequence -> OUT_valid drops to 0 immediately, without waiting for a clock edge.
